// File: rtl/prog_counter_pkg.sv
// Shared types for the programmable counter: count modes and run/done state.
// Pure declarations, no logic.
// Imported by prog_counter and prog_counter_prescaler.
package prog_counter_pkg;

  // MODE_RSVD is decoded exactly like MODE_FREE by the counter.
  typedef enum logic [1:0] {
    MODE_FREE    = 2'd0,
    MODE_WRAP    = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage

// File: rtl/prog_counter_prescaler.sv
// Enabled-cycle divider: TICK on every (PRESCALE+1)th cycle with EN high.
// Latency: TICK is combinational from the registered phase and EN.
// No backpressure; CLR restarts the phase at 0.
module prog_counter_prescaler #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      EN,
  input  logic                      CLR,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TICK
);

  localparam logic [PRESCALE_WIDTH-1:0] PH_ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

  logic [PRESCALE_WIDTH-1:0] phase;

  // '>=' rather than '==' so that shrinking PRESCALE below the current phase
  // ticks at the next compare instead of waiting for the phase to roll over.
  assign TICK = EN && (phase >= PRESCALE);

  // Phase advances only on enabled cycles and restarts after each tick.
  always_ff @(posedge CLK) begin
    if (!RSTN || CLR) begin
      phase <= '0;
    end else if (TICK) begin
      phase <= '0;
    end else if (EN) begin
      phase <= phase + PH_ONE;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with FREE/WRAP/ONESHOT modes, TC pulse, sticky overflow.
// Latency: VALUE/TC/OVERFLOW/DONE all update one edge after the controlling inputs.
// No backpressure. Optional prescaler enabled by macro PROG_COUNTER_PRESCALER_EN.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      EN,
  input  logic                      CLR,
  input  logic                      LOAD,
  input  logic [WIDTH-1:0]          LOAD_VALUE,
  input  logic                      DIR,
  input  logic [1:0]                MODE,
  input  logic [WIDTH-1:0]          LIMIT,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      OVF_CLR,
  output logic [WIDTH-1:0]          VALUE,
  output logic                      TC,
  output logic                      OVERFLOW,
  output logic                      DONE
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state;
  state_e           state_nxt;
  mode_e            mode;
  logic [WIDTH-1:0] value_nxt;
  logic             tc_nxt;
  logic             ovf_set;
  logic             tick;
  logic             step;

  assign mode = mode_e'(MODE);

`ifdef PROG_COUNTER_PRESCALER_EN
  // LOAD also restarts the prescaler so a reload begins a fresh interval.
  prog_counter_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .EN       (EN),
    .CLR      (CLR | LOAD),
    .PRESCALE (PRESCALE),
    .TICK     (tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign tick            = 1'b1;
`endif

  assign step = EN && tick && (state == ST_RUN);
  assign DONE = (state == ST_DONE);

  // Next value/state: CLR beats LOAD beats a counting step.
  always_comb begin
    value_nxt = VALUE;
    tc_nxt    = 1'b0;
    ovf_set   = 1'b0;
    state_nxt = state;
    if (CLR) begin
      value_nxt = '0;
      state_nxt = ST_RUN;
    end else if (LOAD) begin
      value_nxt = LOAD_VALUE;
      state_nxt = ST_RUN;
    end else if (step) begin
      case (mode)
        MODE_WRAP: begin
          if (DIR) begin
            if (VALUE >= LIMIT) begin
              value_nxt = '0;
              tc_nxt    = 1'b1;
            end else begin
              value_nxt = VALUE + ONE;
            end
          end else begin
            if (VALUE == '0) begin
              value_nxt = LIMIT;
              tc_nxt    = 1'b1;
            end else begin
              value_nxt = VALUE - ONE;
            end
          end
        end
        MODE_ONESHOT: begin
          if (DIR) begin
            if (VALUE >= LIMIT) begin
              value_nxt = LIMIT;
              tc_nxt    = 1'b1;
              state_nxt = ST_DONE;
            end else begin
              value_nxt = VALUE + ONE;
            end
          end else begin
            if (VALUE == '0) begin
              tc_nxt    = 1'b1;
              state_nxt = ST_DONE;
            end else begin
              value_nxt = VALUE - ONE;
            end
          end
        end
        default: begin
          // FREE and the reserved encoding: plain modulo-2^WIDTH counting.
          if (DIR) begin
            value_nxt = VALUE + ONE;
            if (VALUE == '1) begin
              tc_nxt  = 1'b1;
              ovf_set = 1'b1;
            end
          end else begin
            value_nxt = VALUE - ONE;
            if (VALUE == '0) begin
              tc_nxt  = 1'b1;
              ovf_set = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Run/done state register.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Count, terminal pulse and sticky overflow; a set event wins over OVF_CLR.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      VALUE    <= '0;
      TC       <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      VALUE <= value_nxt;
      TC    <= tc_nxt;
      if (CLR) begin
        OVERFLOW <= 1'b0;
      end else if (ovf_set) begin
        OVERFLOW <= 1'b1;
      end else if (OVF_CLR) begin
        OVERFLOW <= 1'b0;
      end
    end
  end

endmodule
